// File: rtl/dma_audio_fifo_gen.sv
// DMA sound back end: a word FIFO filled by sound loads and drained at a
// selectable sample rate, producing unsigned 8-bit stereo or mono samples.
module dma_audio_fifo_gen #(
  parameter int DEPTH_BITS = 3,
  parameter int BASE_DIV   = 640,
  parameter int SREQ_GAP   = 0
) (
  input  logic                  clk32,
  input  logic                  reset,
  input  logic [2:0]            mode,
  input  logic                  SLOAD_N,
  input  logic [15:0]           MDIN,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic                  SREQ,
  output logic [DEPTH_BITS:0]   level,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  sample_strobe,
  output logic [7:0]            audio_left,
  output logic [7:0]            audio_right
);

  localparam int PW    = DEPTH_BITS + 1;
  localparam int CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PW-1:0]    CAP      = PW'(2 ** DEPTH_BITS);
  localparam logic [PW-1:0]    GAP      = PW'(SREQ_GAP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BASE_DIV - 1);

  logic [15:0]      mem [2 ** DEPTH_BITS];
  logic [PW-1:0]    wp, rp;
  logic             sload_d, mono_d, bytesel;
  logic [CNT_W-1:0] base_cnt;
  logic [2:0]       div;

  logic        base_tick, rate_hit, tick, mono;
  logic        empty, full, ld, take, starve, pop, push, drop;
  logic [15:0] head;
  logic [7:0]  mono_byte;

  // Signed PCM byte to offset-binary DAC code.
  function automatic logic [7:0] to_offset_binary(input logic signed [7:0] s);
    return 8'(s) ^ 8'h80;
  endfunction

  assign level = wp - rp;
  assign empty = (level == '0);
  assign full  = (level == CAP);
  assign SREQ  = (CAP - level) > GAP;

  assign base_tick = (base_cnt == CNT_LAST);

  always_comb begin
    rate_hit = 1'b0;
    case (mode[1:0])
      2'b11:   rate_hit = 1'b1;
      2'b10:   rate_hit = (div[0] == 1'b0);
      2'b01:   rate_hit = (div[1:0] == 2'b00);
      default: rate_hit = (div == 3'b000);
    endcase
  end

  assign tick = base_tick & rate_hit;
  assign mono = mode[2];

  // Flush outranks every FIFO event, including flag-setting ones.
  assign take   = tick & ~empty & ~flush;
  assign starve = tick & empty & ~flush;
  assign pop    = take & (~mono | bytesel);
  assign ld     = sload_d & ~SLOAD_N;
  assign push   = ld & (~full | pop) & ~flush;
  assign drop   = ld & full & ~pop & ~flush;

  assign head      = mem[rp[DEPTH_BITS-1:0]];
  assign mono_byte = bytesel ? head[7:0] : head[15:8];

  // Stage p0: FIFO write
  always_ff @(posedge clk32) begin
    if (push) mem[wp[DEPTH_BITS-1:0]] <= MDIN;
  end

  // Stage p1: pointers, timebase, flags and sample output registers
  always_ff @(posedge clk32) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      sload_d       <= 1'b1;
      mono_d        <= mode[2];
      base_cnt      <= '0;
      div           <= '0;
      bytesel       <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
      sample_strobe <= 1'b0;
      audio_left    <= 8'h80;
      audio_right   <= 8'h80;
    end else begin
      sload_d  <= SLOAD_N;
      mono_d   <= mode[2];
      base_cnt <= base_tick ? '0 : base_cnt + 1'b1;
      if (base_tick) div <= div + 3'd1;

      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
      end

      if (flush || (mono != mono_d)) bytesel <= 1'b0;
      else if (take && mono)          bytesel <= ~bytesel;

      sample_strobe <= take;
      if (take) begin
        audio_left  <= to_offset_binary(mono ? mono_byte : head[15:8]);
        audio_right <= to_offset_binary(mono ? mono_byte : head[7:0]);
      end

      underrun <= starve | (underrun & ~clr_flags);
      overrun  <= drop | (overrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_dma_audio_fifo_gen.sv
// Directed bench for dma_audio_fifo_gen: fill/overrun, stereo and mono
// playback, rate timing with underrun, coincident events and request threshold.
module tb_dma_audio_fifo_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mode = 3'b011;
  logic        sload_n = 1'b1;
  logic        sload_n2 = 1'b1;
  logic [15:0] mdin = '0;
  logic        flush = 1'b0;
  logic        clr_flags = 1'b0;

  logic        sreq, underrun, overrun, strobe;
  logic [3:0]  level;
  logic [7:0]  left, right;
  logic        sreq2, underrun2, overrun2, strobe2;
  logic [2:0]  level2;
  logic [7:0]  left2, right2;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;

  dma_audio_fifo_gen dut (
    .clk32(clk), .reset(reset), .mode(mode), .SLOAD_N(sload_n), .MDIN(mdin),
    .flush(flush), .clr_flags(clr_flags), .SREQ(sreq), .level(level),
    .underrun(underrun), .overrun(overrun), .sample_strobe(strobe),
    .audio_left(left), .audio_right(right)
  );

  dma_audio_fifo_gen #(.DEPTH_BITS(2), .BASE_DIV(1000), .SREQ_GAP(2)) dut2 (
    .clk32(clk), .reset(reset), .mode(mode), .SLOAD_N(sload_n2), .MDIN(mdin),
    .flush(flush), .clr_flags(clr_flags), .SREQ(sreq2), .level(level2),
    .underrun(underrun2), .overrun(overrun2), .sample_strobe(strobe2),
    .audio_left(left2), .audio_right(right2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [2:0] m);
    mode = m;
    reset = 1'b1;
    sload_n = 1'b1;
    sload_n2 = 1'b1;
    flush = 1'b0;
    clr_flags = 1'b0;
    step(3);
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic load(input logic [15:0] w);
    mdin = w;
    sload_n = 1'b0;
    step(1);
    sload_n = 1'b1;
    step(3);
  endtask

  task automatic load2(input logic [15:0] w);
    mdin = w;
    sload_n2 = 1'b0;
    step(1);
    sload_n2 = 1'b1;
    step(3);
  endtask

  // which: 0 = sample_strobe, 1 = underrun
  task automatic wait_for(input int which, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      step(1);
      n++;
      if ((which == 0 && strobe) || (which == 1 && underrun)) begin
        ok = 1'b1;
        n = budget;
      end
    end
  endtask

  task automatic test_reset;
    mode = 3'b011;
    reset = 1'b1;
    step(2);
    checks++; if (sreq !== 1'b1) begin errors++; $display("FAIL rst_sreq_in_reset got %b exp 1", sreq); end
    reset = 1'b0;
    t0 = cyc;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (underrun !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", underrun, overrun); end
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b exp 0", strobe); end
    checks++; if (left !== 8'h80 || right !== 8'h80) begin errors++; $display("FAIL rst_audio got %h/%h exp 80/80", left, right); end
  endtask

  task automatic test_fill;
    load(16'h7F80); load(16'h1234); load(16'h5678); load(16'h9ABC);
    checks++; if (level !== 4'd4 || sreq !== 1'b1) begin errors++; $display("FAIL fill_half got level %0d sreq %b exp 4 1", level, sreq); end
    load(16'hDEF0); load(16'h1111); load(16'h2222); load(16'h3333);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level got %0d exp 8", level); end
    checks++; if (sreq !== 1'b0) begin errors++; $display("FAIL fill_sreq got %b exp 0", sreq); end
    load(16'h4444);
    checks++; if (overrun !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL fill_overrun got ovr %b level %0d exp 1 8", overrun, level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL fill_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_stereo;
    bit ok;
    int t1;
    wait_for(0, 700, ok);
    checks++; if (!ok || (cyc - t0) !== 640) begin errors++; $display("FAIL st_first_tick got ok %b at %0d exp 640", ok, cyc - t0); end
    t1 = cyc;
    checks++; if (left !== 8'hFF || right !== 8'h00) begin errors++; $display("FAIL st_sample0 got %h/%h exp FF/00", left, right); end
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL st_level0 got %0d exp 7", level); end
    step(1);
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL st_strobe_width got %b exp 0", strobe); end
    wait_for(0, 700, ok);
    checks++; if (!ok || (cyc - t1) !== 640) begin errors++; $display("FAIL st_period got ok %b at %0d exp 640", ok, cyc - t1); end
    checks++; if (left !== 8'h92 || right !== 8'hB4 || level !== 4'd6) begin errors++; $display("FAIL st_sample1 got %h/%h lvl %0d exp 92/B4 6", left, right, level); end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    checks++; if (level !== 4'd0 || left !== 8'h92 || overrun !== 1'b1) begin errors++; $display("FAIL st_flush got lvl %0d left %h ovr %b exp 0 92 1", level, left, overrun); end
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL st_clr_flags got %b exp 0", overrun); end
  endtask

  task automatic test_mono;
    bit ok;
    logic [7:0] exp_b [4] = '{8'h81, 8'h82, 8'h83, 8'h84};
    logic [3:0] exp_l [4] = '{4'd2, 4'd1, 4'd1, 4'd0};
    mode = 3'b111;
    load(16'h0102);
    load(16'h0304);
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL mono_loaded got %0d exp 2", level); end
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 700, ok);
      checks++; if (!ok || left !== exp_b[i] || right !== exp_b[i]) begin errors++; $display("FAIL mono_sample%0d got ok %b %h/%h exp %h", i, ok, left, right, exp_b[i]); end
      checks++; if (level !== exp_l[i]) begin errors++; $display("FAIL mono_level%0d got %0d exp %0d", i, level, exp_l[i]); end
      step(1);
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mono_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_underrun;
    bit ok;
    int tu;
    do_reset(3'b000);
    wait_for(1, 700, ok);
    checks++; if (!ok || (cyc - t0) !== 640) begin errors++; $display("FAIL ur_first got ok %b at %0d exp 640", ok, cyc - t0); end
    tu = cyc;
    checks++; if (left !== 8'h80 || right !== 8'h80 || strobe !== 1'b0) begin errors++; $display("FAIL ur_outputs got %h/%h strobe %b exp 80/80 0", left, right, strobe); end
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %b exp 0", underrun); end
    wait_for(1, 5200, ok);
    checks++; if (!ok || (cyc - tu) !== 5120) begin errors++; $display("FAIL ur_period got ok %b at %0d exp 5120", ok, cyc - tu); end
  endtask

  task automatic test_back_to_back;
    do_reset(3'b011);
    load(16'hA1B2); load(16'h0001); load(16'h0002); load(16'h0003);
    load(16'h0004); load(16'h0005); load(16'h0006); load(16'h0007);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_full got %0d exp 8", level); end
    while (cyc < t0 + 639) step(1);
    mdin = 16'h0008;
    sload_n = 1'b0;
    step(1);
    sload_n = 1'b1;
    checks++; if (strobe !== 1'b1 || left !== 8'h21 || right !== 8'h32) begin errors++; $display("FAIL b2b_pop got strobe %b %h/%h exp 1 21/32", strobe, left, right); end
    checks++; if (level !== 4'd8 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_load got lvl %0d ovr %b exp 8 0", level, overrun); end
    step(2);
    mdin = 16'h0009;
    sload_n = 1'b0;
    flush = 1'b1;
    step(1);
    sload_n = 1'b1;
    flush = 1'b0;
    checks++; if (level !== 4'd0 || overrun !== 1'b0 || left !== 8'h21) begin errors++; $display("FAIL b2b_flush got lvl %0d ovr %b left %h exp 0 0 21", level, overrun, left); end
  endtask

  task automatic test_sreq_gap;
    do_reset(3'b011);
    checks++; if (sreq2 !== 1'b1 || level2 !== 3'd0) begin errors++; $display("FAIL gap_lvl0 got sreq %b lvl %0d exp 1 0", sreq2, level2); end
    for (int i = 1; i <= 4; i++) begin
      load2(16'h1000 + 16'(i));
      checks++; if (level2 !== 3'(i) || sreq2 !== (i < 2)) begin errors++; $display("FAIL gap_lvl%0d got sreq %b lvl %0d exp %b %0d", i, sreq2, level2, (i < 2), i); end
    end
    load2(16'h2000);
    checks++; if (overrun2 !== 1'b1 || level2 !== 3'd4) begin errors++; $display("FAIL gap_overrun got ovr %b lvl %0d exp 1 4", overrun2, level2); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    step(1);
    test_reset;
    test_fill;
    test_stereo;
    test_mono;
    test_underrun;
    test_back_to_back;
    test_sreq_gap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
